// File: rtl/pe_host_seq.sv
// Host-side sequencer for a PE job. It streams 2*VECTOR_SIZE operand words into the
// shared BRAM, starts the PE, waits for completion or timeout, then returns the result word.
module pe_host_seq #(
  parameter int VECTOR_SIZE = 16,
  parameter int L_RAM_SIZE  = 4,
  parameter int TIMEOUT     = 4096
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [31:0] m_result,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_err,
  output logic        pe_start,
  input  logic        pe_done,
  output logic [31:0] BRAM_ADDR,
  output logic [31:0] BRAM_WRDATA,
  output logic [3:0]  BRAM_WE,
  input  logic [31:0] BRAM_RDDATA,
  output logic        busy
);

  localparam int WIDX_W = L_RAM_SIZE + 1;
  localparam int WCNT_W = $clog2(TIMEOUT + 1);
  localparam logic [WIDX_W-1:0] LAST_IDX  = WIDX_W'(2 * VECTOR_SIZE - 1);
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_START,
    S_WAIT,
    S_READ,
    S_CAPT,
    S_OUT
  } state_t;

  state_t              state_q, state_d;
  logic [WIDX_W-1:0]   word_idx_q, word_idx_d;
  logic [WCNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [31:0]         m_result_q, m_result_d;
  logic                m_err_q, m_err_d;
  logic                accept;

  assign s_ready = (state_q == S_IDLE) || (state_q == S_FILL);
  // Gating with aresetn keeps the BRAM write port quiet for the whole reset window.
  assign accept  = s_valid && s_ready && aresetn;

  always_comb begin
    state_d    = state_q;
    word_idx_d = word_idx_q;
    wait_cnt_d = wait_cnt_q;
    m_result_d = m_result_q;
    m_err_d    = m_err_q;
    case (state_q)
      S_IDLE: begin
        word_idx_d = '0;
        if (accept) begin
          word_idx_d = WIDX_W'(1);
          state_d    = S_FILL;
        end
      end
      S_FILL: begin
        if (accept) begin
          word_idx_d = word_idx_q + WIDX_W'(1);
          if (word_idx_q == LAST_IDX) state_d = S_START;
        end
      end
      S_START: begin
        wait_cnt_d = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        // A done arriving on the last counted cycle still wins over the timeout.
        if (pe_done) begin
          state_d = S_READ;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d    = S_OUT;
          m_result_d = 32'hFFFF_FFFF;
          m_err_d    = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WCNT_W'(1);
        end
      end
      S_READ: state_d = S_CAPT;
      S_CAPT: begin
        m_result_d = BRAM_RDDATA;
        m_err_d    = 1'b0;
        state_d    = S_OUT;
      end
      S_OUT: begin
        if (m_ready) begin
          state_d    = S_IDLE;
          word_idx_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q    <= S_IDLE;
      word_idx_q <= '0;
      wait_cnt_q <= '0;
      m_result_q <= '0;
      m_err_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_idx_q <= word_idx_d;
      wait_cnt_q <= wait_cnt_d;
      m_result_q <= m_result_d;
      m_err_q    <= m_err_d;
    end
  end

  // Outside the fill phase the host port sits at address 0, which doubles as the result read.
  assign BRAM_WE     = accept ? 4'hF : 4'h0;
  assign BRAM_ADDR   = s_ready ? 32'({word_idx_q, 2'b00}) : 32'h0;
  assign BRAM_WRDATA = s_ready ? s_data : 32'h0;

  assign pe_start = aresetn && (state_q == S_START);
  assign m_valid  = aresetn && (state_q == S_OUT);
  assign busy     = (state_q != S_IDLE);
  assign m_result = m_result_q;
  assign m_err    = m_err_q;

endmodule
